// File: rtl/bloco_controle_if.sv
// Control/handshake bundle between bloco_controle, the bo datapath and the
// system that owns the operands.
interface bloco_controle_if;
  logic       start;
  logic [1:0] M0;
  logic [1:0] M1;
  logic [1:0] M2;
  logic       h;
  logic       load_x;
  logic       load_h;
  logic       load_l;
  logic       pronto;
  logic       busy;

  modport master (
    input  start,
    output M0, M1, M2, h, load_x, load_h, load_l, pronto, busy
  );

  modport slave (
    output start,
    input  M0, M1, M2, h, load_x, load_h, load_l, pronto, busy
  );
endinterface

// File: rtl/bloco_controle.sv
// Moore FSM sequencing bo through y = ((a*x) + b)*x + c; each ULA operation is
// held for ULA_LAT cycles and its result loaded only in the last one.
module bloco_controle #(
  parameter int unsigned ULA_LAT = 1,
  parameter int unsigned CNT_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  bloco_controle_if.master  bus
);

  localparam logic [2:0] S_OCIOSO  = 3'd0;
  localparam logic [2:0] S_CARGA_X = 3'd1;
  localparam logic [2:0] S_MUL_AX  = 3'd2;
  localparam logic [2:0] S_SOMA_B  = 3'd3;
  localparam logic [2:0] S_MUL_X   = 3'd4;
  localparam logic [2:0] S_SOMA_C  = 3'd5;
  localparam logic [2:0] S_PRONTO  = 3'd6;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ULA_LAT - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_op;

  logic [1:0] w_m0;
  logic [1:0] w_m1;
  logic [1:0] w_m2;
  logic       w_h;
  logic       w_load_x;
  logic       w_load_h;
  logic       w_load_l;
  logic       w_pronto;
  logic       w_busy;

  assign w_last = (r_cnt == LAST);
  assign w_op   = (r_state == S_MUL_AX) || (r_state == S_SOMA_B) ||
                  (r_state == S_MUL_X)  || (r_state == S_SOMA_C);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_OCIOSO:  if (bus.start) w_state_nxt = S_CARGA_X;
      S_CARGA_X: w_state_nxt = S_MUL_AX;
      S_MUL_AX:  w_state_nxt = S_SOMA_B;
      S_SOMA_B:  w_state_nxt = S_MUL_X;
      S_MUL_X:   w_state_nxt = S_SOMA_C;
      S_SOMA_C:  w_state_nxt = S_PRONTO;
      S_PRONTO:  if (!bus.start) w_state_nxt = S_OCIOSO;
      default:   w_state_nxt = S_OCIOSO;
    endcase
    // operation states hold until the hold counter reaches its last count
    if (w_op && !w_last) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_OCIOSO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_m0     = 2'b00;
    w_m1     = 2'b00;
    w_m2     = 2'b00;
    w_h      = 1'b0;
    w_load_x = 1'b0;
    w_load_h = 1'b0;
    w_load_l = 1'b0;
    w_pronto = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      S_CARGA_X: begin
        w_load_x = 1'b1;
        w_busy   = 1'b1;
      end
      S_MUL_AX: begin
        w_m0     = 2'b01;
        w_m1     = 2'b01;
        w_m2     = 2'b01;
        w_h      = 1'b1;
        w_load_h = w_last;
        w_busy   = 1'b1;
      end
      S_SOMA_B: begin
        w_m0     = 2'b10;
        w_m1     = 2'b11;
        w_m2     = 2'b00;
        w_load_h = w_last;
        w_busy   = 1'b1;
      end
      S_MUL_X: begin
        w_m1     = 2'b11;
        w_m2     = 2'b01;
        w_h      = 1'b1;
        w_load_h = w_last;
        w_busy   = 1'b1;
      end
      S_SOMA_C: begin
        w_m0     = 2'b11;
        w_m1     = 2'b11;
        w_m2     = 2'b00;
        w_load_l = w_last;
        w_busy   = 1'b1;
      end
      S_PRONTO: w_pronto = 1'b1;
      default:  ;
    endcase
  end

  assign bus.M0     = w_m0;
  assign bus.M1     = w_m1;
  assign bus.M2     = w_m2;
  assign bus.h      = w_h;
  assign bus.load_x = w_load_x;
  assign bus.load_h = w_load_h;
  assign bus.load_l = w_load_l;
  assign bus.pronto = w_pronto;
  assign bus.busy   = w_busy;

endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: two instances (ULA_LAT=1 and 3), each driving a
// behavioural bo datapath whose gated output is checked against a queue.
module tb_bloco_controle;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [15:0] y;
  } vec_t;

  logic clock;
  logic reset;
  logic [7:0] xv, av, bv, cv;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q1[$];
  logic [15:0] q3[$];

  bloco_controle_if i1();
  bloco_controle_if i3();

  bloco_controle #(.ULA_LAT(1), .CNT_W(2)) u1 (.clock(clock), .reset(reset), .bus(i1));
  bloco_controle #(.ULA_LAT(3), .CNT_W(2)) u3 (.clock(clock), .reset(reset), .bus(i3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural bo: mux0, ULA operand muxes, x/H/L registers, pronto-gated output
  function automatic logic [15:0] ula(input logic [1:0] s0, input logic [1:0] s1,
                                      input logic [1:0] s2, input logic hh,
                                      input logic [15:0] xr, input logic [15:0] hr,
                                      input logic [15:0] sd);
    logic [15:0] m0, o1, o2;
    case (s0)
      2'b00: m0 = 16'h0;
      2'b01: m0 = {8'h0, av};
      2'b10: m0 = {8'h0, bv};
      default: m0 = {8'h0, cv};
    endcase
    case (s1)
      2'b00: o1 = xr;
      2'b01: o1 = m0;
      2'b10: o1 = sd;
      default: o1 = hr;
    endcase
    case (s2)
      2'b00: o2 = m0;
      2'b01: o2 = xr;
      2'b10: o2 = sd;
      default: o2 = hr;
    endcase
    return hh ? 16'(o1 * o2) : 16'(o1 + o2);
  endfunction

  logic [15:0] x1, h1, l1, x3, h3, l3;
  wire  [15:0] saida1 = i1.pronto ? l1 : 16'h0;
  wire  [15:0] saida3 = i3.pronto ? l3 : 16'h0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      x1 <= '0; h1 <= '0; l1 <= '0;
    end else begin
      if (i1.load_x) x1 <= {8'h0, xv};
      if (i1.load_h) h1 <= ula(i1.M0, i1.M1, i1.M2, i1.h, x1, h1, saida1);
      if (i1.load_l) l1 <= ula(i1.M0, i1.M1, i1.M2, i1.h, x1, h1, saida1);
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      x3 <= '0; h3 <= '0; l3 <= '0;
    end else begin
      if (i3.load_x) x3 <= {8'h0, xv};
      if (i3.load_h) h3 <= ula(i3.M0, i3.M1, i3.M2, i3.h, x3, h3, saida3);
      if (i3.load_l) l3 <= ula(i3.M0, i3.M1, i3.M2, i3.h, x3, h3, saida3);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every pronto rise pops one expected result
  logic p1_d = 1'b0;
  logic p3_d = 1'b0;
  always @(negedge clock) begin
    if (i1.pronto && !p1_d) begin
      if (q1.size() == 0) check("u1_unexpected_pronto", 1, 0);
      else check("u1_result", int'(saida1), int'(q1.pop_front()));
    end
    if (i3.pronto && !p3_d) begin
      if (q3.size() == 0) check("u3_unexpected_pronto", 1, 0);
      else check("u3_result", int'(saida3), int'(q3.pop_front()));
    end
    p1_d = i1.pronto;
    p3_d = i3.pronto;
  end

  // packed {M0,M1,M2,h,load_x,load_h,load_l,pronto,busy}
  function automatic logic [11:0] outs(input int sel);
    if (sel == 0)
      return {i1.M0, i1.M1, i1.M2, i1.h, i1.load_x, i1.load_h, i1.load_l, i1.pronto, i1.busy};
    return {i3.M0, i3.M1, i3.M2, i3.h, i3.load_x, i3.load_h, i3.load_l, i3.pronto, i3.busy};
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) i1.start = v;
    else i3.start = v;
  endtask

  function automatic logic [2:0] exp_load(input int i, input int lat);
    int op, k;
    if (i == 0) return 3'b100;
    op = (i - 1) / lat;
    k  = (i - 1) % lat;
    if (k != lat - 1) return 3'b000;
    return (op == 3) ? 3'b001 : 3'b010;
  endfunction

  function automatic logic [6:0] exp_sel(input int i, input int lat);
    if (i == 0) return 7'b0;
    case ((i - 1) / lat)
      0: return 7'b01_01_01_1;
      1: return 7'b10_11_00_0;
      2: return 7'b00_11_01_1;
      default: return 7'b11_11_00_0;
    endcase
  endfunction

  // mode 0: normal; 1: start 1->0->1 during SOMA_B; 2: start dropped early
  task automatic run_seq(input int sel, input vec_t v, input int lat,
                         input int hold, input int mode);
    int nc;
    logic [11:0] o;
    nc = 1 + 4 * lat;
    xv = v.x; av = v.a; bv = v.b; cv = v.c;
    if (sel == 0) q1.push_back(v.y);
    else q3.push_back(v.y);
    set_start(sel, 1'b1);
    for (int i = 0; i < nc; i++) begin
      @(negedge clock);
      o = outs(sel);
      check($sformatf("loads_u%0d_c%0d", sel, i), int'(o[4:2]), int'(exp_load(i, lat)));
      check($sformatf("selects_u%0d_c%0d", sel, i), int'(o[11:5]), int'(exp_sel(i, lat)));
      check($sformatf("busy_u%0d_c%0d", sel, i), int'(o[1:0]), 1);
      if (mode == 1 && i == 1 + lat) set_start(sel, 1'b0);
      if (mode == 1 && i == 2 + lat) set_start(sel, 1'b1);
      if (mode == 2 && i == 1) set_start(sel, 1'b0);
    end
    @(negedge clock);
    check($sformatf("pronto_rise_u%0d", sel), int'(outs(sel)), 12'h002);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check($sformatf("pronto_hold_u%0d", sel), int'(outs(sel)), 12'h002);
    end
    set_start(sel, 1'b0);
    @(negedge clock);
    check($sformatf("back_idle_u%0d", sel), int'(outs(sel)), 0);
  endtask

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] o;
    tbl[0] = '{x: 8'd3,   a: 8'd2,   b: 8'd5,   c: 8'd7,   y: 16'd40};
    tbl[1] = '{x: 8'd0,   a: 8'd9,   b: 8'd9,   c: 8'd4,   y: 16'd4};
    tbl[2] = '{x: 8'd255, a: 8'd1,   b: 8'd0,   c: 8'd0,   y: 16'd65025};
    tbl[3] = '{x: 8'd1,   a: 8'd1,   b: 8'd1,   c: 8'd1,   y: 16'd3};
    tbl[4] = '{x: 8'd10,  a: 8'd3,   b: 8'd4,   c: 8'd5,   y: 16'd345};
    tbl[5] = '{x: 8'd255, a: 8'd255, b: 8'd255, c: 8'd255, y: 16'd511};

    reset = 1'b0;
    i1.start = 1'b0;
    i3.start = 1'b0;
    xv = '0; av = '0; bv = '0; cv = '0;
    repeat (2) @(negedge clock);
    check("reset_u1", int'(outs(0)), 0);
    check("reset_u3", int'(outs(1)), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_u1", int'(outs(0)), 0);

    // back-to-back runs, single OCIOSO cycle between them
    for (int k = 0; k < 6; k++) run_seq(0, tbl[k], 1, 0, 0);
    for (int k = 0; k < 2; k++) run_seq(1, tbl[k], 3, 0, 0);

    run_seq(1, tbl[5], 3, 20, 0);
    run_seq(1, tbl[0], 3, 0, 1);
    run_seq(1, tbl[4], 3, 0, 2);
    run_seq(0, tbl[4], 1, 0, 2);
    repeat (3) @(negedge clock);
    check("no_extra_run_u3", int'(outs(1)), 0);

    // reset pulse of half a cycle while u1 is in MUL_X
    xv = tbl[0].x; av = tbl[0].a; bv = tbl[0].b; cv = tbl[0].c;
    set_start(0, 1'b1);
    repeat (4) @(negedge clock);
    o = outs(0);
    check("in_mul_x", int'(o[11:5]), 7'b00_11_01_1);
    set_start(0, 1'b0);
    reset = 1'b0;
    #1;
    check("async_reset_u1", int'(outs(0)), 0);
    #3;
    reset = 1'b1;
    q1.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("post_reset_idle", int'(outs(0)), 0);
    end
    run_seq(0, tbl[1], 1, 0, 0);

    repeat (2) @(negedge clock);
    check("queue_u1_drained", q1.size(), 0);
    check("queue_u3_drained", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
